// File: rtl/i2c_bit_engine.sv
// Bit-level I2C master: executes one START / TX byte / RX byte / STOP command per request,
// drives push-pull SCL and open-drain SDA, and reports completion through a ready level.
module i2c_bit_engine #(
    parameter int QTR_CYC  = 250,
    parameter int HOLD_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] next_step,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       ready,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int QW = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [QW-1:0] QTR_LAST  = QW'(QTR_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    localparam logic [1:0] CMD_END   = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_TX    = 2'b10;
    localparam logic [1:0] CMD_RX    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_START, S_TXBIT, S_TXACK, S_RXBIT, S_RXACK, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q, bit_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            ready_q, ready_d;
    logic            ack_err_q, ack_err_d;
    logic            bus_active_q, bus_active_d;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;
    logic            sda_s1_q, sda_s1_d;
    logic            sda_s2_q, sda_s2_d;

    logic in_cell;
    logic qtr_end;
    logic cell_end;
    logic sample_pt;
    logic scl_hi;

    assign in_cell   = (state_q != S_IDLE) && (state_q != S_HOLD);
    assign qtr_end   = (qcnt_q == QTR_LAST);
    assign cell_end  = qtr_end && (quarter_q == 2'd3);
    // Data is sampled as the cell enters Q2, the middle of the SCL high phase.
    assign sample_pt = qtr_end && (quarter_q == 2'd1);
    assign scl_hi    = (quarter_q == 2'd1) || (quarter_q == 2'd2);

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        quarter_d    = quarter_q;
        bit_d        = bit_q;
        hcnt_d       = hcnt_q;
        tx_d         = tx_q;
        rx_shift_d   = rx_shift_q;
        rx_byte_d    = rx_byte_q;
        ready_d      = ready_q;
        ack_err_d    = ack_err_q;
        bus_active_d = bus_active_q;
        scl_d        = scl_q;
        sda_oe_d     = sda_oe_q;
        sda_s1_d     = sda_in;
        sda_s2_d     = sda_s1_q;

        if (in_cell) begin
            qcnt_d = qtr_end ? '0 : qcnt_q + 1'b1;
            if (qtr_end) quarter_d = quarter_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
                ready_d  = 1'b0;
                qcnt_d   = '0;
                quarter_d = '0;
                if (next_step == CMD_START) begin
                    state_d = S_START;
                end else if (next_step == CMD_END && bus_active_q) begin
                    state_d = S_STOP;
                end
            end
            S_HOLD: begin
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == HOLD_LAST) begin
                    ready_d   = 1'b0;
                    tx_d      = tx_byte;
                    qcnt_d    = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    hcnt_d    = '0;
                    case (next_step)
                        CMD_START: state_d = S_START;
                        CMD_TX:    state_d = S_TXBIT;
                        CMD_RX:    state_d = S_RXBIT;
                        default:   state_d = S_STOP;
                    endcase
                end
            end
            S_START: begin
                scl_d    = scl_hi;
                sda_oe_d = quarter_q[1];
                if (cell_end) begin
                    bus_active_d = 1'b1;
                    state_d      = S_HOLD;
                    ready_d      = 1'b1;
                    hcnt_d       = '0;
                end
            end
            S_TXBIT: begin
                scl_d    = scl_hi;
                sda_oe_d = ~tx_q[bit_q];
                if (cell_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_TXACK;
                end
            end
            S_TXACK: begin
                scl_d    = scl_hi;
                sda_oe_d = 1'b0;
                if (sample_pt) ack_err_d = sda_s2_q;
                if (cell_end) begin
                    state_d = S_HOLD;
                    ready_d = 1'b1;
                    hcnt_d  = '0;
                end
            end
            S_RXBIT: begin
                scl_d    = scl_hi;
                sda_oe_d = 1'b0;
                if (sample_pt) rx_shift_d[bit_q] = sda_s2_q;
                if (cell_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d   = S_RXACK;
                        rx_byte_d = rx_shift_q;
                    end
                end
            end
            S_RXACK: begin
                scl_d    = scl_hi;
                sda_oe_d = ~tx_q[0];
                if (cell_end) begin
                    state_d = S_HOLD;
                    ready_d = 1'b1;
                    hcnt_d  = '0;
                end
            end
            S_STOP: begin
                scl_d    = (quarter_q != 2'd0);
                sda_oe_d = ~quarter_q[1];
                if (cell_end) begin
                    bus_active_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            qcnt_q       <= '0;
            quarter_q    <= '0;
            bit_q        <= '0;
            hcnt_q       <= '0;
            tx_q         <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            ready_q      <= 1'b0;
            ack_err_q    <= 1'b0;
            bus_active_q <= 1'b0;
            scl_q        <= 1'b1;
            sda_oe_q     <= 1'b0;
            sda_s1_q     <= 1'b1;
            sda_s2_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            quarter_q    <= quarter_d;
            bit_q        <= bit_d;
            hcnt_q       <= hcnt_d;
            tx_q         <= tx_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            ready_q      <= ready_d;
            ack_err_q    <= ack_err_d;
            bus_active_q <= bus_active_d;
            scl_q        <= scl_d;
            sda_oe_q     <= sda_oe_d;
            sda_s1_q     <= sda_s1_d;
            sda_s2_q     <= sda_s2_d;
        end
    end

    assign rx_byte = rx_byte_q;
    assign ready   = ready_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;

endmodule
